key_schedule: RTL and testbench
===============================

# key_schedule

Sequential DES key-schedule generator sitting directly downstream of the PC-1 permutation. Takes the 28-bit C0/D0 halves produced by PC-1, applies the per-round rotations, and emits the 16 48-bit round subkeys through the PC-2 selection, one per handshake. Supports both encryption order (K1..K16) and decryption order (K16..K1), so the Feistel round datapath can consume subkeys serially without storing a 768-bit table.

## Interface

Parameters: none (DES constants are fixed).

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: **synchronous, active-high reset**.
- start, in, 1: request a new schedule; accepted only while busy=0.
- decrypt, in, 1: sampled with start; 0 = K1..K16 order, 1 = K16..K1 order.
- cbits, in, 29: C0 half from PC-1; bits 1..28 in DES numbering, bit 1 first; bit 0 ignored.
- dbits, in, 29: D0 half from PC-1; same numbering; bit 0 ignored.
- busy, out, 1: a schedule is in progress.
- subkey, out, 49: current round key; bits 1..48 in DES numbering, bit 0 driven 0.
- subkey_valid, out, 1: subkey is valid.
- subkey_ready, in, 1: consumer accepts subkey this cycle.
- round, out, 4: DES round index of the current subkey, minus 1 (0 = K1 … 15 = K16).
- done, out, 1: one-cycle pulse after the 16th subkey is accepted.

## Operation

- States: IDLE, RUN.
- Registers: c_reg[28:1], d_reg[28:1], count[3:0] (handshakes completed), mode.
- Rotation, DES numbering:
  - Left by 1: new[i] = old[i+1], new[28] = old[1].
  - Right rotation is the inverse.
- SHIFT table, rounds 1..16: 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1.
- IDLE, start=1:
  - Encrypt: load C/D = rotl(C0/D0, SHIFT[1]).
  - Decrypt: load C0/D0 unrotated. This gives C16/D16, because the total rotation is 28.
  - Set count=0, latch mode, go to RUN.
- RUN, subkey_valid and subkey_ready both high:
  - Encrypt: rotate C/D left by SHIFT[count+2].
  - Decrypt: rotate C/D right by SHIFT[16-count].
  - Increment count.
  - On the 16th accept (count=15), go to IDLE and pulse done.
- Output mapping:
  - subkey = PC2(c_reg, d_reg), combinational from registered state. It is stable while subkey_valid=1.
  - subkey_valid = (state==RUN).
  - round = count in encrypt mode; 15-count in decrypt mode.
- PC2: subkey[j] = CD[PC2[j]], where CD[1..28]=C and CD[29..56]=D. PC2 = 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
- start while busy=1 is ignored. The decrypt input is ignored except when start is accepted.
- cbits/dbits are sampled only on the accepted start cycle.

## Timing

- Reset values: state=IDLE, busy=0, subkey_valid=0, done=0, round=0, subkey=0, c_reg/d_reg=0.
- Start accepted in cycle T → busy=1 and subkey_valid=1 with the first key at T+1.
- No backpressure (subkey_ready held 1): keys at T+1..T+16, one per cycle; done=1 and busy=0 at T+17.
- subkey_ready=0 holds subkey, round and state unchanged indefinitely.
- start asserted in the same cycle as done: accepted, because busy=0 then; next schedule begins the following cycle.
- rst mid-schedule: IDLE on the next edge, all outputs at reset values, no done pulse.
- rst has priority over start.

## Structure

- Shared package des_pkg:
  - SHIFT table.
  - PC2 index constants.
  - State enum.
  - Rotate-left/right-by-1/2 functions.
- Sub-module pc2: combinational 56→48 selection, same 1-based port numbering convention as PC-1.
- Top: FSM, C/D registers, counter.

## Test plan

Test key 0x133457799BBCDFF1 → C0=0xF0CCAAF, D0=0x556678F. Hex values are {x[1],…,x[n]}, MSB first.

1. **Encrypt order.** Encrypt, ready=1 → K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5 at T+1, T+2, T+16; done at T+17.
2. **Decrypt order.** Decrypt, ready=1 → first subkey 0xCB3D8B0E17F5 with round=15, last 0x1B02EFFC7072 with round=0; matches scenario 1 reversed.
3. **Backpressure.** Encrypt, ready randomly 0 for 1–5 cycles → subkey/round constant while stalled; same 16-key sequence; done only after the 16th accept.
4. **start while busy.** Assert start with a different key during RUN → ignored; sequence unchanged.
5. **Reset mid-schedule.** rst at round 7 → next cycle busy=0, subkey_valid=0, subkey=0, no done; a fresh start then gives K1=0x1B02EFFC7072.
6. **Back-to-back schedules.** start coincident with done → second schedule begins next cycle, no gap key, correct K1.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES key-schedule constants, state encoding and rotate helpers
package des_pkg;

    typedef logic [28:1] half_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Rotation amount for rounds 1..16, stored at index round-1
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Source bit in CD[1..56] for subkey bits 1..48, stored at index j-1
    localparam logic [5:0] PC2_IDX [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Left rotation in DES numbering moves bit i+1 into bit i
    function automatic half_t rotl(input half_t x, input logic [1:0] n);
        return (n == 2'd2) ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
    endfunction

    function automatic half_t rotr(input half_t x, input logic [1:0] n);
        return (n == 2'd2) ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
    endfunction

endpackage

// File: rtl/key_schedule_pc2.sv
// rtl/key_schedule_pc2.sv - PC-2 selection of 48 subkey bits from the 56-bit C/D pair
module pc2
    import des_pkg::*;
(
    input  logic [28:1] c,
    input  logic [28:1] d,
    output logic [48:1] k
);

    logic [56:1] cd;

    assign cd = {d, c};

    for (genvar j = 1; j <= 48; j++) begin : g_sel
        assign k[j] = cd[PC2_IDX[j-1]];
    end

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - serial DES round-subkey generator, encrypt or decrypt order
module key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [28:0] cbits,
    input  logic [28:0] dbits,
    output logic        busy,
    output logic [48:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        done
);

    state_t      state, state_next;
    half_t       c_reg, d_reg, c_next, d_next;
    logic [3:0]  count, count_next;
    logic        mode, mode_next;
    logic        done_next;
    logic [48:1] key;
    logic        unused_bits;

    assign unused_bits = ^{cbits[0], dbits[0]};

    always_comb begin
        state_next = state;
        c_next     = c_reg;
        d_next     = d_reg;
        count_next = count;
        mode_next  = mode;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = 4'd0;
                    mode_next  = decrypt;
                    // C0/D0 already equal C16/D16, so decrypt starts unrotated
                    if (decrypt) begin
                        c_next = cbits[28:1];
                        d_next = dbits[28:1];
                    end else begin
                        c_next = rotl(cbits[28:1], SHIFT[0]);
                        d_next = rotl(dbits[28:1], SHIFT[0]);
                    end
                end
            end
            RUN: begin
                if (subkey_ready) begin
                    count_next = count + 4'd1;
                    if (mode) begin
                        c_next = rotr(c_reg, SHIFT[4'd15 - count]);
                        d_next = rotr(d_reg, SHIFT[4'd15 - count]);
                    end else begin
                        c_next = rotl(c_reg, SHIFT[count + 4'd1]);
                        d_next = rotl(d_reg, SHIFT[count + 4'd1]);
                    end
                    if (count == 4'd15) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            c_reg <= '0;
            d_reg <= '0;
            count <= 4'd0;
            mode  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            c_reg <= c_next;
            d_reg <= d_next;
            count <= count_next;
            mode  <= mode_next;
            done  <= done_next;
        end
    end

    pc2 u_pc2 (
        .c (c_reg),
        .d (d_reg),
        .k (key)
    );

    assign busy         = (state == RUN);
    assign subkey_valid = (state == RUN);
    assign subkey       = {key, 1'b0};
    assign round        = mode ? (4'd15 - count) : count;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule against a hex-domain DES model
module tb_key_schedule;

    logic        clk = 1'b0;
    logic        rst, start, decrypt, subkey_ready;
    logic [28:0] cbits, dbits;
    logic        busy, subkey_valid, done;
    logic [48:0] subkey;
    logic [3:0]  round;

    int errors = 0;
    int checks = 0;

    logic [47:0] exp_k [16];
    logic [47:0] got   [16];

    int sh   [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int pc2t [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                      26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                      51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam logic [27:0] TC0 = 28'hF0CCAAF;
    localparam logic [27:0] TD0 = 28'h556678F;
    localparam logic [47:0] K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .cbits        (cbits),
        .dbits        (dbits),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
        logic [55:0] w;
        w = {x, x} << s;
        return w[55:28];
    endfunction

    // Hex values are MSB-first, so DES bit p of a 56-bit CD word sits at position 56-p
    function automatic logic [47:0] pc2f(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-pc2t[j]];
        return r;
    endfunction

    task automatic build_model(input logic [27:0] c0, input logic [27:0] d0);
        logic [27:0] c, d;
        c = c0;
        d = d0;
        for (int r = 0; r < 16; r++) begin
            c = rotl28(c, sh[r]);
            d = rotl28(d, sh[r]);
            exp_k[r] = pc2f(c, d);
        end
    endtask

    function automatic logic [28:0] to_des28(input logic [27:0] h);
        logic [28:0] v;
        for (int i = 1; i <= 28; i++) v[i] = h[28-i];
        v[0] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [47:0] from_des48(input logic [48:0] s);
        logic [47:0] h;
        for (int j = 1; j <= 48; j++) h[48-j] = s[j];
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issues start in the current cycle and ends on the done cycle without stepping past it
    task automatic run_sched(input logic [27:0] c0, input logic [27:0] d0,
                             input logic dec, input bit bp, input bit poke);
        int n, idx, stall, cyc;
        build_model(c0, d0);
        chk("busy_before_start", 64'(busy), 64'd0);
        start        = 1'b1;
        decrypt      = dec;
        cbits        = to_des28(c0);
        dbits        = to_des28(d0);
        subkey_ready = 1'b1;
        step;
        start   = 1'b0;
        decrypt = 1'($urandom);
        n       = 0;
        cyc     = 0;
        stall   = bp ? $urandom_range(1, 5) : 0;
        while (n < 16 && cyc < 400) begin
            idx          = dec ? 15 - n : n;
            subkey_ready = (stall == 0);
            start        = poke && (n == 5);
            if (start) begin
                decrypt = ~dec;
                cbits   = 29'($urandom);
                dbits   = 29'($urandom);
            end
            chk("valid", 64'(subkey_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("subkey", 64'(from_des48(subkey)), 64'(exp_k[idx]));
            chk("subkey_bit0", 64'(subkey[0]), 64'd0);
            chk("round", 64'(round), 64'(idx));
            chk("done_early", 64'(done), 64'd0);
            if (subkey_ready) begin
                got[n] = from_des48(subkey);
                n++;
                stall = (bp && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, 5) : 0;
            end else begin
                stall--;
            end
            step;
            cyc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b1;
        chk("keys_delivered", 64'(n), 64'd16);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("valid_after", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        logic [27:0] rc, rd;
        logic        rdec;
        bit          rbp;

        rst          = 1'b1;
        start        = 1'b0;
        decrypt      = 1'b0;
        cbits        = '0;
        dbits        = '0;
        subkey_ready = 1'b1;
        step;
        start = 1'b1;
        step;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        step;

        // Encrypt order on the reference key
        run_sched(TC0, TD0, 1'b0, 1'b0, 1'b0);
        chk("enc_k1", 64'(got[0]), 64'(K1));
        chk("enc_k2", 64'(got[1]), 64'(K2));
        chk("enc_k16", 64'(got[15]), 64'(K16));
        step;
        chk("done_one_cycle", 64'(done), 64'd0);

        // Decrypt order
        run_sched(TC0, TD0, 1'b1, 1'b0, 1'b0);
        chk("dec_first", 64'(got[0]), 64'(K16));
        chk("dec_last", 64'(got[15]), 64'(K1));
        step;

        // Backpressure
        run_sched(TC0, TD0, 1'b0, 1'b1, 1'b0);
        chk("bp_k16", 64'(got[15]), 64'(K16));
        step;

        // start while busy must be ignored
        run_sched(TC0, TD0, 1'b0, 1'b0, 1'b1);
        chk("poke_k16", 64'(got[15]), 64'(K16));
        step;
        chk("poke_no_restart", 64'(busy), 64'd0);

        // Reset in the middle of a schedule
        start   = 1'b1;
        decrypt = 1'b0;
        cbits   = to_des28(TC0);
        dbits   = to_des28(TD0);
        step;
        start = 1'b0;
        for (int i = 0; i < 20 && round != 4'd6; i++) step;
        chk("reach_round7", 64'(round), 64'd6);
        rst   = 1'b1;
        start = 1'b1;
        step;
        rst   = 1'b0;
        start = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_subkey", 64'(subkey), 64'd0);
        chk("midrst_round", 64'(round), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        step;
        chk("midrst_no_done", 64'(done), 64'd0);
        run_sched(TC0, TD0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_k1", 64'(got[0]), 64'(K1));
        step;

        // Back-to-back: each new start lands on the previous done cycle
        run_sched(28'($urandom), 28'($urandom), 1'b0, 1'b0, 1'b0);
        run_sched(TC0, TD0, 1'b1, 1'b0, 1'b0);
        run_sched(TC0, TD0, 1'b0, 1'b0, 1'b0);
        chk("b2b_k1", 64'(got[0]), 64'(K1));
        step;
        chk("b2b_done_clear", 64'(done), 64'd0);

        // Random keys, modes and backpressure
        for (int t = 0; t < 8; t++) begin
            rc   = 28'($urandom);
            rd   = 28'($urandom);
            rdec = 1'($urandom);
            rbp  = 1'($urandom);
            run_sched(rc, rd, rdec, rbp, 1'b0);
            step;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
